// File: rtl/adder_operand_sequencer.sv
// Operand/result sequencer around a combinational OP_W-bit adder: gathers A, B and
// carry-in from a narrow word stream, captures sum/carry after one settle cycle, drains the result.
module adder_operand_sequencer #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned OP_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_cin,
    output logic [OP_W-1:0]   adder_a,
    output logic [OP_W-1:0]   adder_b,
    output logic              adder_cin,
    input  logic [OP_W-1:0]   adder_sum,
    input  logic              adder_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              out_cout,
    output logic              busy
);

    localparam int unsigned NWORDS = OP_W / WORD_W;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EXEC,
        DRAIN
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic              cin_q;
    logic [OP_W-1:0]   res_q;
    logic              cout_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic              in_xfer;
    logic              out_xfer;
    logic              cnt_last;

    always_comb begin
        in_xfer  = in_valid && in_ready_q;
        out_xfer = out_valid_q && out_ready;
        cnt_last = (cnt_q == CNT_LAST);
        cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    end

    // Handshake flags are registered alongside the state so they change only on edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (in_xfer) begin
                        a_q[cnt_q*WORD_W +: WORD_W] <= in_data;
                        cnt_q <= cnt_d;
                        if (cnt_last) begin
                            state_q <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_xfer) begin
                        b_q[cnt_q*WORD_W +: WORD_W] <= in_data;
                        cnt_q <= cnt_d;
                        if (cnt_last) begin
                            cin_q      <= in_cin;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // Operands have been stable for a full cycle; the adder output is settled.
                    res_q       <= adder_sum;
                    cout_q      <= adder_cout;
                    out_valid_q <= 1'b1;
                    state_q     <= DRAIN;
                end
                DRAIN: begin
                    if (out_xfer) begin
                        cnt_q <= cnt_d;
                        if (cnt_last) begin
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= LOAD_A;
                        end
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign adder_a   = a_q;
    assign adder_b   = b_q;
    assign adder_cin = cin_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? res_q[cnt_q*WORD_W +: WORD_W] : '0;
    assign out_last  = out_valid_q && cnt_last;
    assign out_cout  = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Randomized bench for adder_operand_sequencer: a word-count/queue reference model checked
// every cycle, plus literal expectations for the directed operand cases.
`timescale 1ns/1ps
module tb_adder_operand_sequencer;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 64;
    localparam int unsigned NWORDS = OP_W / WORD_W;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_cin   = 1'b0;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] in_data  = '0;
    logic              in_ready, adder_cin, adder_cout, out_valid, out_last, out_cout, busy;
    logic [OP_W-1:0]   adder_a, adder_b, adder_sum;
    logic [WORD_W-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the combinational ripple adder.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{OP_W{1'b0}}, adder_cin};

    adder_operand_sequencer #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_cin (adder_cin),
        .adder_sum (adder_sum),
        .adder_cout(adder_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [OP_W-1:0] pack(input logic [WORD_W-1:0] w [NWORDS]);
        logic [OP_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NWORDS; i++) v[i*WORD_W +: WORD_W] = w[i];
        return v;
    endfunction

    // Reference model: words accepted so far, a pending-exec flag and a queue of result words.
    logic [WORD_W-1:0] m_a [NWORDS];
    logic [WORD_W-1:0] m_b [NWORDS];
    logic              m_cin, m_cout, m_exec;
    int                m_nin;
    logic [WORD_W-1:0] m_q [$];

    function automatic void mdl_reset();
        for (int unsigned i = 0; i < NWORDS; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_cin  = 1'b0;
        m_cout = 1'b0;
        m_exec = 1'b0;
        m_nin  = 0;
        m_q.delete();
    endfunction

    always @(negedge clk) begin
        logic            exp_ready;
        logic [OP_W:0]   full;
        if (!rst_n) mdl_reset();
        exp_ready = !m_exec && (m_q.size() == 0);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("busy", busy, !exp_ready);
        chk("adder_a", adder_a, pack(m_a));
        chk("adder_b", adder_b, pack(m_b));
        chk("adder_cin", adder_cin, m_cin);
        if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0]);
            chk("out_last", out_last, m_q.size() == 1);
            chk("out_cout", out_cout, m_cout);
        end
        if (!rst_n) begin
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_cout", out_cout, 0);
        end else begin
            if (m_q.size() != 0) begin
                if (out_ready) void'(m_q.pop_front());
            end else if (m_exec) begin
                full = {1'b0, pack(m_a)} + {1'b0, pack(m_b)} + (OP_W+1)'(m_cin);
                m_cout = full[OP_W];
                for (int unsigned i = 0; i < NWORDS; i++) m_q.push_back(full[i*WORD_W +: WORD_W]);
                m_exec = 1'b0;
            end else if (in_valid) begin
                if (m_nin < int'(NWORDS)) m_a[m_nin] = in_data;
                else m_b[m_nin - NWORDS] = in_data;
                if (m_nin == int'(2*NWORDS) - 1) begin
                    m_cin  = in_cin;
                    m_exec = 1'b1;
                    m_nin  = 0;
                end else begin
                    m_nin++;
                end
            end
        end
    end

    logic [WORD_W-1:0] got_w [NWORDS];
    logic              got_cout;
    int                got_n;

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the last word.
    task automatic load_words(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                              input logic [2*NWORDS-1:0] cin_mask, input int nwords, input int gap_pct);
        int idx = 0;
        int cyc = 0;
        while (idx < nwords && cyc < 400) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            if (idx < int'(NWORDS)) in_data = a[idx*WORD_W +: WORD_W];
            else in_data = b[(idx-NWORDS)*WORD_W +: WORD_W];
            in_cin = cin_mask[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_cin   = 1'b0;
        in_data  = '0;
        chk("load_words_done", idx, nwords);
    endtask

    // mode 0: always ready, 1: ready low 3 valid cycles before each word, 2: random ready
    task automatic drain_words(input int nmax, input int mode);
        int  cyc   = 0;
        int  stall = 0;
        bit  done  = 0;
        got_n = 0;
        got_cout = 1'b0;
        for (int unsigned i = 0; i < NWORDS; i++) got_w[i] = '0;
        while (!done && got_n < nmax && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (stall >= 3);
                default: out_ready = ($urandom_range(99) < 60);
            endcase
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_w[got_n] = out_data;
                got_cout = out_cout;
                done = out_last;
                got_n++;
                stall = 0;
            end else if (out_valid) begin
                stall++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [OP_W-1:0] exp_sum, input logic exp_cout);
        chk({tag, "_nwords"}, got_n, NWORDS);
        for (int unsigned i = 0; i < NWORDS; i++)
            chk($sformatf("%s_w%0d", tag, i), got_w[i], exp_sum[i*WORD_W +: WORD_W]);
        chk({tag, "_cout"}, got_cout, exp_cout);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_cout"}, out_cout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_adder_a"}, adder_a, 0);
        chk({tag, "_adder_b"}, adder_b, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OP_W-1:0]       ra, rb;
        logic [2*NWORDS-1:0]   rm;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // All zero; pin the two-edge latency to first out_valid.
        load_words(64'h0, 64'h0, 8'h00, 8, 0);
        @(negedge clk);
        chk("lat_exec_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_drain_out_valid", out_valid, 1);
        chk("lat_drain_out_last", out_last, 0);
        drain_words(4, 0);
        check_result("zero", 64'h0, 1'b0);

        load_words(64'h3000_0000_0000_0000, 64'h4000_0000_0000_0000, 8'h00, 8, 0);
        drain_words(4, 0);
        check_result("top", 64'h7000_0000_0000_0000, 1'b0);

        load_words('1, '1, 8'h80, 8, 0);
        drain_words(4, 0);
        check_result("ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        load_words('1, '1, 8'h7F, 8, 0);
        drain_words(4, 0);
        check_result("ones_early_cin", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);

        load_words(64'h7A14_0000_FFFF_FFFF, 64'h6606_0000_FFFF_FFFF, 8'h80, 8, 0);
        drain_words(4, 1);
        check_result("stall", 64'hE01A_0001_FFFF_FFFF, 1'b0);

        // Reset after two B words, then a full operation.
        load_words(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 8'hFF, 6, 30);
        pulse_reset("rst_load");
        load_words(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 8'h80, 8, 30);
        drain_words(4, 2);
        check_result("post_rst_load", 64'h0000_0000_0000_000D, 1'b0);

        // Reset mid-drain on a result with carry-out set.
        load_words('1, 64'h1, 8'h00, 8, 0);
        drain_words(1, 0);
        pulse_reset("rst_drain");
        load_words(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 8'h00, 8, 20);
        drain_words(4, 2);
        check_result("post_rst_drain", 64'h0000_0000_0000_0001, 1'b1);

        for (int unsigned t = 0; t < 24; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rm = 8'($urandom);
            load_words(ra, rb, rm, 8, 40);
            chk("rand_adder_a", adder_a, ra);
            chk("rand_adder_b", adder_b, rb);
            chk("rand_adder_cin", adder_cin, rm[2*NWORDS-1]);
            drain_words(4, 2);
            check_result("rand", ra + rb + {{(OP_W-1){1'b0}}, rm[2*NWORDS-1]},
                         (({1'b0, ra} + {1'b0, rb} + {{OP_W{1'b0}}, rm[2*NWORDS-1]}) >> OP_W) != 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
